// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - round-robin interrupt scheduler with edge-detected, maskable requests
// Optional unacknowledged-irq abandon timeout is built when IRQ_TIMEOUT_EN is defined.
module irq_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               irq_ack,
    input  logic               flag_clr,
    output logic               irq,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] missed,
    output logic               timeout_flag
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               irq_q, irq_d;
    logic [IDW-1:0]     irq_id_q, irq_id_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0] req_q, req_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] missed_q, missed_d;

    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] ack_clr;
    logic               sel_found;
    logic [IDW-1:0]     sel_idx;
    int                 rr_idx;

`ifdef IRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tflag_q, tflag_d;
    logic               timeout_fire;
`endif

    assign req_d = req;
    assign evt   = req & ~req_q & mask;

    // Round-robin search begins one past the last serviced source.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_idx    = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            rr_idx = int'(last_grant_q) + k;
            if (rr_idx >= NUM_SRC) begin
                rr_idx = rr_idx - NUM_SRC;
            end
            if (!sel_found && pending_q[rr_idx[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        last_grant_d = last_grant_q;
        ack_clr      = '0;
`ifdef IRQ_TIMEOUT_EN
        cnt_d        = '0;
        timeout_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    irq_d    = 1'b1;
                    irq_id_d = sel_idx;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (irq_ack) begin
                    ack_clr[irq_id_q] = 1'b1;
                    irq_d             = 1'b0;
                    last_grant_d      = irq_id_q;
                    state_d           = GAP;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon without clearing pending so the source is retried.
                    timeout_fire = 1'b1;
                    irq_d        = 1'b0;
                    last_grant_d = irq_id_q;
                    state_d      = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            GAP: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A new edge on a source being acked this cycle wins and is not a miss.
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | evt;
        missed_d  = (flag_clr ? '0 : missed_q) | (evt & pending_q & ~ack_clr);
    end

`ifdef IRQ_TIMEOUT_EN
    always_comb begin
        tflag_d = (flag_clr ? 1'b0 : tflag_q) | timeout_fire;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            last_grant_q <= IDW'(NUM_SRC - 1);
            req_q        <= '0;
            pending_q    <= '0;
            missed_q     <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            pending_q    <= pending_d;
            missed_q     <= missed_d;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign irq     = irq_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;
    assign missed  = missed_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - directed self-checking bench for irq_scheduler
module tb_irq_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] mask;
    logic       irq_ack;
    logic       flag_clr;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] missed;
    logic       timeout_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_scheduler #(.NUM_SRC(4), .TIMEOUT(16), .IDW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mask         (mask),
        .irq_ack      (irq_ack),
        .flag_clr     (flag_clr),
        .irq          (irq),
        .irq_id       (irq_id),
        .pending      (pending),
        .missed       (missed),
        .timeout_flag (timeout_flag)
    );

    task automatic wait_irq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        reset = 1'b0; req = 4'b0100; mask = 4'hF; irq_ack = 1'b0; flag_clr = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({irq, irq_id} !== 3'b000) begin
            n_bad++; $display("FAIL reset_irq: got irq=%b id=%0d expected irq=0 id=0", irq, irq_id);
        end
        n_cmp++;
        if ({pending, missed, timeout_flag} !== 9'b0) begin
            n_bad++; $display("FAIL reset_flags: got pend=%b miss=%b to=%b expected all 0", pending, missed, timeout_flag);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pending !== 4'b0100) begin
            n_bad++; $display("FAIL req_high_at_release: got pend=%b expected 0100", pending);
        end
        req = 4'b0000;
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd2) begin
            n_bad++; $display("FAIL release_grant: got ok=%b id=%0d expected ok=1 id=2", ok, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        req = 4'b0010; @(negedge clk);
        req = 4'b0000;
        n_cmp++;
        if (pending !== 4'b0010 || irq !== 1'b0) begin
            n_bad++; $display("FAIL single_pending: got pend=%b irq=%b expected 0010/0", pending, irq);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 2'd1) begin
            n_bad++; $display("FAIL single_irq: got irq=%b id=%0d expected 1/1", irq, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        n_cmp++;
        if (pending !== 4'b0000 || irq !== 1'b0) begin
            n_bad++; $display("FAIL single_ack: got pend=%b irq=%b expected 0000/0", pending, irq);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin;
        bit ok;
        int exp_id[3] = '{0, 1, 3};
        reset = 1'b0; @(negedge clk); reset = 1'b1;
        req = 4'b1011; @(negedge clk); req = 4'b0000;
        for (int g = 0; g < 3; g++) begin
            wait_irq(ok);
            n_cmp++;
            if (!ok || irq_id !== 2'(exp_id[g])) begin
                n_bad++; $display("FAIL rr_grant%0d: got ok=%b id=%0d expected id=%0d", g, ok, irq_id, exp_id[g]);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if (irq !== 1'b1 || irq_id !== 2'(exp_id[g])) begin
                n_bad++; $display("FAIL rr_hold%0d: got irq=%b id=%0d expected 1/%0d", g, irq, irq_id, exp_id[g]);
            end
            irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
            n_cmp++;
            if (irq !== 1'b0) begin
                n_bad++; $display("FAIL rr_gap%0d: got irq=%b expected 0", g, irq);
            end
        end
        n_cmp++;
        if (pending !== 4'b0000) begin
            n_bad++; $display("FAIL rr_drain: got pend=%b expected 0000", pending);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_missed;
        bit ok;
        req = 4'b0100; @(negedge clk); req = 4'b0000; @(negedge clk);
        req = 4'b0100; @(negedge clk); req = 4'b0000;
        n_cmp++;
        if (missed !== 4'b0100 || pending !== 4'b0100) begin
            n_bad++; $display("FAIL missed_set: got miss=%b pend=%b expected 0100/0100", missed, pending);
        end
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd2) begin
            n_bad++; $display("FAIL missed_grant: got ok=%b id=%0d expected id=2", ok, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        n_cmp++;
        if (missed !== 4'b0100 || pending !== 4'b0000) begin
            n_bad++; $display("FAIL missed_sticky: got miss=%b pend=%b expected 0100/0000", missed, pending);
        end
        flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
        n_cmp++;
        if (missed !== 4'b0000) begin
            n_bad++; $display("FAIL missed_clr: got miss=%b expected 0000", missed);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mask_filter;
        mask = 4'b0111; req = 4'b1000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pending !== 4'b0000 || irq !== 1'b0) begin
            n_bad++; $display("FAIL masked_edge: got pend=%b irq=%b expected 0000/0", pending, irq);
        end
        mask = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pending !== 4'b0000 || irq !== 1'b0) begin
            n_bad++; $display("FAIL unmask_level: got pend=%b irq=%b expected 0000/0", pending, irq);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_same_cycle;
        bit ok;
        req = 4'b0010; @(negedge clk); req = 4'b0000;
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd1) begin
            n_bad++; $display("FAIL same_grant: got ok=%b id=%0d expected id=1", ok, irq_id);
        end
        mask = 4'b1101; @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 2'd1 || pending !== 4'b0010) begin
            n_bad++; $display("FAIL mask_hold: got irq=%b id=%0d pend=%b expected 1/1/0010", irq, irq_id, pending);
        end
        mask = 4'hF; irq_ack = 1'b1; req = 4'b0010; @(negedge clk);
        irq_ack = 1'b0; req = 4'b0000;
        n_cmp++;
        if (irq !== 1'b0 || pending !== 4'b0010 || missed !== 4'b0000) begin
            n_bad++; $display("FAIL set_wins: got irq=%b pend=%b miss=%b expected 0/0010/0000", irq, pending, missed);
        end
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd1) begin
            n_bad++; $display("FAIL same_regrant: got ok=%b id=%0d expected id=1", ok, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mask_pending;
        req = 4'b0001; @(negedge clk);
        mask = 4'b1110; req = 4'b0000; @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 2'd0 || pending !== 4'b0001) begin
            n_bad++; $display("FAIL masked_pending_grant: got irq=%b id=%0d pend=%b expected 1/0/0001", irq, irq_id, pending);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0; mask = 4'hF;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
`ifdef IRQ_TIMEOUT_EN
        int hi;
`endif
        req = 4'b0001; @(negedge clk); req = 4'b0000;
        wait_irq(ok);
`ifdef IRQ_TIMEOUT_EN
        hi = 0;
        while (irq === 1'b1 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi != 16) begin
            n_bad++; $display("FAIL timeout_len: got %0d high cycles expected 16", hi);
        end
        n_cmp++;
        if (timeout_flag !== 1'b1 || pending !== 4'b0001) begin
            n_bad++; $display("FAIL timeout_state: got to=%b pend=%b expected 1/0001", timeout_flag, pending);
        end
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd0) begin
            n_bad++; $display("FAIL timeout_retry: got ok=%b id=%0d expected id=0", ok, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
        n_cmp++;
        if (timeout_flag !== 1'b0) begin
            n_bad++; $display("FAIL timeout_clr: got to=%b expected 0", timeout_flag);
        end
`else
        repeat (20) @(negedge clk);
        n_cmp++;
        if (!ok || irq !== 1'b1 || irq_id !== 2'd0 || timeout_flag !== 1'b0) begin
            n_bad++; $display("FAIL no_timeout: got ok=%b irq=%b id=%0d to=%b expected 1/1/0/0", ok, irq, irq_id, timeout_flag);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        req = 4'b0100; @(negedge clk); req = 4'b0000; @(negedge clk);
        req = 4'b0100; @(negedge clk); req = 4'b0000;
        n_cmp++;
        if (irq !== 1'b1 || missed !== 4'b0100) begin
            n_bad++; $display("FAIL pre_reset: got irq=%b miss=%b expected 1/0100", irq, missed);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({irq, irq_id, pending, missed, timeout_flag} !== 12'b0) begin
            n_bad++; $display("FAIL async_reset: got irq=%b id=%0d pend=%b miss=%b to=%b expected all 0", irq, irq_id, pending, missed, timeout_flag);
        end
        req = 4'b1001;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); req = 4'b0000;
        n_cmp++;
        if (pending !== 4'b1001) begin
            n_bad++; $display("FAIL post_reset_pend: got pend=%b expected 1001", pending);
        end
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd0) begin
            n_bad++; $display("FAIL post_reset_first: got ok=%b id=%0d expected id=0", ok, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        wait_irq(ok);
        n_cmp++;
        if (!ok || irq_id !== 2'd3) begin
            n_bad++; $display("FAIL post_reset_second: got ok=%b id=%0d expected id=3", ok, irq_id);
        end
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_missed();
        test_mask_filter();
        test_same_cycle();
        test_mask_pending();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt requesters (jump key, frame tick, audio, spare); legal 2..8.
REQ-002 Parameter TIMEOUT, default 1023: cycles irq SHALL wait for irq_ack before abandon (used only under IRQ_TIMEOUT_EN).
REQ-003 Parameter IDW, default 2: irq_id width, SHALL equal ceil(log2(NUM_SRC)).
REQ-004 clk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_SRC  per-source request level, synchronous to clk; a rising edge is one event.
REQ-007 mask  in  NUM_SRC  per-source enable; 1 = events accepted.
REQ-008 irq_ack  in  1  CPU acknowledge of the current irq, one-cycle pulse.
REQ-009 flag_clr  in  1  clears all sticky flags.
REQ-010 irq  out  1  interrupt to CPU.
REQ-011 irq_id  out  IDW  index of the source being serviced; valid while irq=1.
REQ-012 pending  out  NUM_SRC  latched, unserviced events.
REQ-013 missed  out  NUM_SRC  sticky: event arrived while that source already pending.
REQ-014 timeout_flag  out  1  sticky: an irq was abandoned unacknowledged.

Function
REQ-015 Edge detect SHALL use one register stage of req; event[i] = req[i] & ~req_q[i] & mask[i]; a masked edge SHALL be discarded, not deferred.
REQ-016 event[i] SHALL set pending[i] on the same clock edge; if pending[i] is already 1 and not being cleared that edge, missed[i] SHALL set.
REQ-017 FSM states IDLE, WAIT_ACK, GAP.
REQ-018 IDLE: if any pending bit is 1, select one by round-robin starting at last_grant+1 (mod NUM_SRC), register irq_id, set irq=1, go to WAIT_ACK; else stay.
REQ-019 Latency: req high first sampled at edge N -> pending at N -> irq=1 after edge N+1 (FSM in IDLE).
REQ-020 WAIT_ACK: irq and irq_id SHALL hold stable; mask changes SHALL NOT withdraw irq.
REQ-021 irq_ack sampled in WAIT_ACK: clear pending[irq_id], irq=0, last_grant=irq_id, go to GAP.
REQ-022 GAP lasts exactly one cycle with irq=0, then IDLE; irq SHALL never stay high across two grants.
REQ-023 irq_ack in IDLE or GAP SHALL be ignored.
REQ-024 New event on the source being cleared in the same cycle: set wins, pending stays 1, missed unchanged.
REQ-025 flag_clr clears missed and timeout_flag; a set in the same cycle wins.
REQ-026 Masking a pending source SHALL NOT clear pending; it SHALL still be granted.

Reset
REQ-027 reset low SHALL immediately force: FSM IDLE, irq=0, irq_id=0, pending=0, missed=0, timeout_flag=0, req_q=0, last_grant=NUM_SRC-1 (source 0 served first), timeout counter 0.
REQ-028 reset asserted during WAIT_ACK SHALL drop irq without clearing-by-ack semantics; no event survives reset.
REQ-029 First event edge detectable on the first clock after reset release; a req already high at release SHALL count as an event.

Configuration
REQ-030 Macro IRQ_TIMEOUT_EN defined: counter increments each WAIT_ACK cycle; when it reaches TIMEOUT without ack, irq=0, pending kept (retried), last_grant=irq_id, timeout_flag=1, go to GAP; counter cleared on leaving WAIT_ACK; ack in the timeout cycle wins (normal ack).
REQ-031 Macro undefined: no counter; WAIT_ACK waits indefinitely; timeout_flag tied 0.

Verification (NUM_SRC=4, TIMEOUT=16)
REQ-032 mask=4'hF, req[1] pulse 1 cycle -> pending=4'b0010 next edge, irq=1 irq_id=1 one edge later; ack -> pending=0, irq low.
REQ-033 req=4'b1011 same cycle, ack each irq after 3 cycles -> grant order 0,1,3, one irq-low GAP cycle between grants.
REQ-034 req[2] pulses twice while pending[2]=1 -> missed=4'b0100; flag_clr -> missed=0.
REQ-035 mask[3]=0, req[3] edge -> pending=0, irq stays 0; later mask[3]=1 with req[3] still high -> no event.
REQ-036 IRQ_TIMEOUT_EN, req[0], no ack -> irq drops after 16 WAIT_ACK cycles, timeout_flag=1, pending[0] still 1, irq reissued id 0 after GAP.
REQ-037 reset low mid-WAIT_ACK -> irq, pending, flags 0 asynchronously; after release source 0 served first.
